// File: rtl/sysid_regs_pkg.sv
// Shared constants for the system-ID register block: word map, CTRL bit layout
// and the capability-word packing.
package sysid_regs_pkg;

    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_CAPS      = 3'd2;
    localparam logic [2:0] ADDR_CTRL      = 3'd3;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd4;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
    localparam logic [2:0] ADDR_SCRATCH0  = 3'd6;
    localparam logic [2:0] ADDR_SCRATCH1  = 3'd7;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;
    localparam int CTRL_OVF = 2;

    localparam int MAX_SCRATCH = 2;

    // CAPS = {16'd0, counter width[7:0], 6'd0, scratch count[1:0]}
    function automatic logic [31:0] caps_word(input int cnt_w, input int num_scratch);
        logic [7:0] width_b;
        logic [1:0] scr_b;
        width_b = cnt_w[7:0];
        scr_b   = num_scratch[1:0];
        return {16'd0, width_b, 6'd0, scr_b};
    endfunction

endpackage

// File: rtl/sysid_uptime_ctr.sv
// Free-running uptime counter with enable, synchronous clear and a sticky
// overflow flag; CTRL writes arrive already qualified by the bus decode.
module sysid_uptime_ctr
    import sysid_regs_pkg::*;
#(
    parameter int CNT_W = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_ctrl_wr,
    input  logic [2:0]       i_ctrl_wdata,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_en,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_en;
    logic             r_ovf;
    logic             w_clr;
    logic             w_wrap;

    assign w_clr  = i_ctrl_wr && i_ctrl_wdata[CTRL_CLR];
    // A clear in the same cycle suppresses the increment, so no wrap occurs.
    assign w_wrap = r_en && !w_clr && (r_cnt == '1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_en  <= 1'b1;
            r_ovf <= 1'b0;
        end else begin
            if (w_clr) begin
                r_cnt <= '0;
            end else if (r_en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (i_ctrl_wr) begin
                r_en <= i_ctrl_wdata[CTRL_EN];
            end
            if (w_wrap) begin
                r_ovf <= 1'b1;
            end else if (i_ctrl_wr && i_ctrl_wdata[CTRL_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_en  = r_en;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/sysid_regs.sv
// Avalon-MM system-ID / uptime register block with single-cycle registered reads,
// a latched upper-word shadow for the uptime counter, and optional scratch words.
module sysid_regs
    import sysid_regs_pkg::*;
#(
    parameter logic [31:0] ID_VALUE    = 32'd7,
    parameter logic [31:0] TIMESTAMP   = 32'd1383176735,
    parameter int          CNT_W       = 48,
    parameter int          NUM_SCRATCH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    logic [CNT_W-1:0] w_cnt;
    logic             w_en;
    logic             w_ovf;
    logic             w_ctrl_wr;
    logic [31:0]      w_rdata;
    logic [31:0]      r_hi;
    logic [31:0]      r_readdata;
    logic             r_rdv;
    logic [31:0]      r_scratch [MAX_SCRATCH];

    assign w_ctrl_wr = write && (address == ADDR_CTRL) && byteenable[0];

    sysid_uptime_ctr #(.CNT_W(CNT_W)) u_ctr (
        .clock        (clock),
        .reset        (reset),
        .i_ctrl_wr    (w_ctrl_wr),
        .i_ctrl_wdata (writedata[2:0]),
        .o_cnt        (w_cnt),
        .o_en         (w_en),
        .o_ovf        (w_ovf)
    );

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_ID:        w_rdata = ID_VALUE;
            ADDR_TIMESTAMP: w_rdata = TIMESTAMP;
            ADDR_CAPS:      w_rdata = caps_word(CNT_W, NUM_SCRATCH);
            ADDR_CTRL: begin
                w_rdata[CTRL_EN]  = w_en;
                w_rdata[CTRL_OVF] = w_ovf;
            end
            ADDR_UPTIME_LO: w_rdata = w_cnt[31:0];
            ADDR_UPTIME_HI: w_rdata = r_hi;
            ADDR_SCRATCH0:  if (NUM_SCRATCH > 0) w_rdata = r_scratch[0];
            ADDR_SCRATCH1:  if (NUM_SCRATCH > 1) w_rdata = r_scratch[1];
            default:        w_rdata = '0;
        endcase
    end

    // Reads sample pre-edge state, so a same-cycle write is never visible yet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
            r_rdv      <= 1'b0;
            r_hi       <= '0;
        end else begin
            r_rdv <= read;
            if (read) begin
                r_readdata <= w_rdata;
            end
            if (read && (address == ADDR_UPTIME_LO)) begin
                r_hi <= 32'(w_cnt >> 32);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < MAX_SCRATCH; s++) begin
                r_scratch[s] <= '0;
            end
        end else begin
            for (int s = 0; s < MAX_SCRATCH; s++) begin
                if ((s < NUM_SCRATCH) && write && (address == 3'(int'(ADDR_SCRATCH0) + s))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byteenable[b]) begin
                            r_scratch[s][8*b +: 8] <= writedata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    assign readdata      = r_readdata;
    assign readdatavalid = r_rdv;

endmodule

// File: tb/tb_sysid_regs.sv
// Bench for sysid_regs: directed checks of the register map, counter control and
// reset behaviour, then random bus traffic against a behavioural model.
module tb_sysid_regs;

    localparam longint unsigned CNT_MASK = (64'd1 << 48) - 64'd1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [31:0] readdata1;
    logic        readdatavalid1;

    int n_vec = 0;
    int n_err = 0;

    longint unsigned m_cnt;
    bit              m_en;
    bit              m_ovf;
    logic [31:0]     m_hi;
    logic [31:0]     m_scr [2];
    logic [31:0]     m_last;
    logic [31:0]     m_last1;

    always #5 clock = ~clock;

    sysid_regs dut (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .readdatavalid(readdatavalid)
    );

    sysid_regs #(.NUM_SCRATCH(1)) dut1 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata1), .readdatavalid(readdatavalid1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_en = 1; m_ovf = 0; m_hi = '0;
        m_scr[0] = '0; m_scr[1] = '0; m_last = '0; m_last1 = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return 32'd7;
            3'd1: return 32'd1383176735;
            3'd2: return (32'd48 << 8) | 32'd2;
            3'd3: return {29'd0, m_ovf, 1'b0, m_en};
            3'd4: return m_cnt[31:0];
            3'd5: return m_hi;
            3'd6: return m_scr[0];
            default: return m_scr[1];
        endcase
    endfunction

    // One bus cycle: drive at negedge, check just after the rising edge, advance the model.
    task automatic cycle(input bit rd, input bit wr, input logic [2:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] exp;
        logic [31:0] exp1;
        bit ctrl_wr;
        bit clr;
        bit wrap;
        @(negedge clock);
        read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        exp  = model_read(a);
        exp1 = (a == 3'd7) ? 32'd0 : exp;
        @(posedge clock);
        #1;
        if (rd) begin
            check("rdv", {31'd0, readdatavalid}, 32'd1);
            check($sformatf("rd[%0d]", a), readdata, exp);
            m_last = exp;
            if (a >= 3'd6) check($sformatf("rd1[%0d]", a), readdata1, exp1);
            m_last1 = exp1;
        end else begin
            check("rdv_idle", {31'd0, readdatavalid}, 32'd0);
            check("hold", readdata, m_last);
        end
        if (rd && a == 3'd4) m_hi = 32'(m_cnt >> 32);
        ctrl_wr = wr && a == 3'd3 && be[0];
        clr     = ctrl_wr && wd[1];
        wrap    = !clr && m_en && m_cnt == CNT_MASK;
        if (clr) m_cnt = 0;
        else if (m_en) m_cnt = (m_cnt + 1) & CNT_MASK;
        if (wrap) m_ovf = 1;
        else if (ctrl_wr && wd[2]) m_ovf = 0;
        if (ctrl_wr) m_en = wd[0];
        if (wr && a >= 3'd6) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) m_scr[a - 3'd6][8*b +: 8] = wd[8*b +: 8];
            end
        end
        read = 0; write = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 3'd0, 32'd0, 4'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_rdata", readdata, 32'd0);
        check("rst_rdv", {31'd0, readdatavalid}, 32'd0);
        reset = 0;

        cycle(1, 0, 3'd0, 0, 0);
        cycle(1, 0, 3'd1, 0, 0);
        cycle(1, 0, 3'd2, 0, 0);
        idle(1);
        cycle(1, 0, 3'd3, 0, 0);
        cycle(1, 0, 3'd4, 0, 0);

        // Disabled window, then re-enable.
        cycle(0, 1, 3'd3, 32'd0, 4'h1);
        cycle(1, 0, 3'd4, 0, 0);
        idle(100);
        cycle(1, 0, 3'd4, 0, 0);
        cycle(0, 1, 3'd3, 32'd1, 4'h1);
        cycle(1, 0, 3'd4, 0, 0);
        cycle(1, 0, 3'd4, 0, 0);

        cycle(0, 1, 3'd3, 32'd0, 4'hE);
        cycle(1, 0, 3'd3, 0, 0);
        cycle(0, 1, 3'd3, 32'd3, 4'h1);
        cycle(1, 0, 3'd4, 0, 0);
        cycle(1, 1, 3'd3, 32'd0, 4'h1);
        cycle(1, 0, 3'd3, 0, 0);
        cycle(0, 1, 3'd3, 32'd1, 4'h1);
        cycle(0, 1, 3'd0, 32'd0, 4'hF);
        cycle(1, 0, 3'd0, 0, 0);

        cycle(0, 1, 3'd6, 32'hA5A5A5A5, 4'b0101);
        cycle(1, 0, 3'd6, 0, 0);
        cycle(0, 1, 3'd7, 32'h12345678, 4'hF);
        cycle(1, 0, 3'd7, 0, 0);

        // Shadow latch across a carry into bit 32.
        force dut.u_ctr.r_cnt = 48'h0001_FFFF_FFFF;
        #1 release dut.u_ctr.r_cnt;
        m_cnt = 64'h0001_FFFF_FFFF;
        cycle(1, 0, 3'd4, 0, 0);
        idle(3);
        cycle(1, 0, 3'd5, 0, 0);
        cycle(1, 0, 3'd5, 0, 0);

        // Wrap sets OVF; W1C clears it.
        force dut.u_ctr.r_cnt = 48'hFFFF_FFFF_FFFE;
        #1 release dut.u_ctr.r_cnt;
        m_cnt = CNT_MASK - 1;
        idle(3);
        cycle(1, 0, 3'd3, 0, 0);
        cycle(1, 0, 3'd4, 0, 0);
        cycle(0, 1, 3'd3, 32'h5, 4'h1);
        cycle(1, 0, 3'd3, 0, 0);

        // Wrap and W1C in the same cycle: set wins.
        force dut.u_ctr.r_cnt = 48'hFFFF_FFFF_FFFF;
        #1 release dut.u_ctr.r_cnt;
        m_cnt = CNT_MASK;
        cycle(0, 1, 3'd3, 32'h5, 4'h1);
        cycle(1, 0, 3'd3, 0, 0);
        cycle(0, 1, 3'd3, 32'h5, 4'h1);
        cycle(1, 0, 3'd3, 0, 0);

        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset during an in-flight read while counting.
        cycle(0, 1, 3'd3, 32'd1, 4'h1);
        idle(5);
        @(negedge clock);
        read = 1; address = 3'd4;
        #2 reset = 1;
        @(posedge clock);
        #1;
        read = 0;
        check("rst_mid_rdv", {31'd0, readdatavalid}, 32'd0);
        check("rst_mid_rdata", readdata, 32'd0);
        #1 reset = 0;
        model_reset();
        cycle(1, 0, 3'd4, 0, 0);
        idle(1);
        cycle(1, 0, 3'd3, 0, 0);
        cycle(1, 0, 3'd5, 0, 0);
        cycle(1, 0, 3'd6, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sysid_regs.md
SYSID_REGS -- requirements
Module: sysid_regs

Interface
REQ-001 SHALL have parameter ID_VALUE, default 7: 32-bit system ID returned at word 0.
REQ-002 SHALL have parameter TIMESTAMP, default 1383176735: 32-bit build timestamp returned at word 1.
REQ-003 SHALL have parameter CNT_W, default 48: uptime counter width, legal 33..64.
REQ-004 SHALL have parameter NUM_SCRATCH, default 2: scratch register count, legal 0..2.
REQ-005 SHALL have port clock, input, 1: sole clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port address, input, 3: Avalon-MM word address.
REQ-008 SHALL have port read, input, 1: read strobe, one transfer per asserted cycle.
REQ-009 SHALL have port write, input, 1: write strobe, one transfer per asserted cycle.
REQ-010 SHALL have port writedata, input, 32: write data.
REQ-011 SHALL have port byteenable, input, 4: write byte lanes.
REQ-012 SHALL have port readdata, output, 32: registered read data.
REQ-013 SHALL have port readdatavalid, output, 1: qualifies readdata.

Function
REQ-014 SHALL use the map: 0 ID (RO), 1 TIMESTAMP (RO), 2 CAPS (RO), 3 CTRL (RW), 4 UPTIME_LO (RO), 5 UPTIME_HI (RO shadow), 6 SCRATCH0, 7 SCRATCH1.
REQ-015 SHALL return readdata and readdatavalid exactly 1 cycle after read; no waitrequest; back-to-back reads each cycle supported.
REQ-016 SHALL hold readdata at its last value and readdatavalid=0 in cycles without a pending read.
REQ-017 SHALL return CAPS = {16'd0, CNT_W[7:0], 6'd0, NUM_SCRATCH[1:0]}.
REQ-018 SHALL implement CTRL bit0 EN (RW, reset 1), bit1 CLR (write-1 pulse, reads 0), bit2 OVF (sticky, write-1-to-clear); other bits read 0.
REQ-019 SHALL increment the uptime counter by 1 per cycle while EN=1; hold when EN=0.
REQ-020 SHALL wrap counter from 2^CNT_W-1 to 0 and set OVF in that cycle.
REQ-021 SHALL, on CLR write, zero the counter next cycle (clear beats increment); CLR does not change OVF.
REQ-022 SHALL give OVF set priority over a same-cycle write-1-to-clear.
REQ-023 SHALL, on a read of UPTIME_LO, return counter bits [31:0] and latch bits [CNT_W-1:32] (zero-extended) into the HI shadow in the same edge.
REQ-024 SHALL return the HI shadow on reads of UPTIME_HI, unaffected by counter motion.
REQ-025 SHALL return pre-update values when a read and a write/CLR/increment hit the same register in the same cycle.
REQ-026 SHALL apply byteenable per lane on SCRATCH writes; CTRL writes take effect only when byteenable[0]=1.
REQ-027 SHALL return 0 and ignore writes for scratch words at or above NUM_SCRATCH.
REQ-028 SHALL ignore writes to RO words; read and write together in one cycle SHALL both execute.

Reset
REQ-029 SHALL on reset: readdata=0, readdatavalid=0, counter=0, HI shadow=0, EN=1, OVF=0, scratch=0.
REQ-030 SHALL drop any in-flight read on reset (no readdatavalid after deassertion for it).

Structure
REQ-031 SHALL place address constants, CTRL bit positions and CAPS layout in package sysid_regs_pkg.
REQ-032 SHALL implement counter, wrap/OVF and CLR/EN logic in sub-module sysid_uptime_ctr.

Verification
REQ-033 Reads of words 0,1,2 after reset -> 7, 1383176735, 0x00003002, each with readdatavalid one cycle later.
REQ-034 Write CTRL=0 for 100 cycles, then UPTIME_LO -> value unchanged across window; write CTRL=1 -> increments resume.
REQ-035 Force counter to 2^48-2 (CNT_W=48), run 3 cycles -> wraps to 0 or 1, OVF=1; write CTRL=0x5 -> OVF=0.
REQ-036 Read LO when counter=0x1_FFFF_FFFF -> LO=0xFFFFFFFF; later HI read -> 1 even after carry.
REQ-037 Write SCRATCH0=0xA5A5A5A5 byteenable=0b0101 over 0 -> read 0x00A500A5; SCRATCH1 with NUM_SCRATCH=1 -> 0.
REQ-038 Assert reset mid-read and mid-count -> readdatavalid=0, counter=0, CTRL reads 0x1.
